// File: rtl/sha256_block_engine.sv
// sha256_block_engine
//   SHA-256 compression engine for the miner datapath. Accepts one 512-bit
//   message block per valid/ready handshake, runs the 64 rounds with
//   ROUNDS_PER_CYCLE (1, 2 or 4) rounds folded into each clock, chains the
//   intermediate hash across blocks and presents the 256-bit digest together
//   with a one-cycle digest_valid strobe after every block.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   blk_valid     block offered by the padder/loader
//   blk_ready     engine idle and able to accept a block
//   blk_data      message block, W0 in [511:480] ... W15 in [31:0]
//   blk_first     1 = start from the IV, 0 = chain from the previous digest
//   busy          high while rounds or the final hash update are running
//   digest_valid  one-cycle pulse, digest updated this cycle
//   digest        H0 in [255:224] ... H7 in [31:0], held between updates
module sha256_block_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam int ROUND_CYCLES = 64 / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_param
    $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Counter value at the start of the last round cycle.
  localparam logic [5:0] LAST_CNT = 6'((ROUND_CYCLES - 1) * ROUNDS_PER_CYCLE);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] work_q [8];   // a..h
  logic [31:0] work_d [8];
  logic [31:0] w_q    [16];  // w_q[0] is W[t] for the next round to run
  logic [31:0] w_d    [16];
  logic [31:0] h_q    [8];   // chaining value
  logic [31:0] h_d    [8];
  logic [255:0] digest_q, digest_d;
  logic         dv_q, dv_d;

  // Unrolled round chain: stage gi applies round cnt_q+gi and shifts the
  // schedule window by one word, so the last stage holds the state after
  // ROUNDS_PER_CYCLE rounds.
  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : stg
    logic [31:0] wi [16];
    logic [31:0] si [8];
    logic [31:0] wo [16];
    logic [31:0] so [8];
    logic [31:0] t1, t2, w_new;

    if (gi == 0) begin : g_src
      assign wi = w_q;
      assign si = work_q;
    end else begin : g_src
      assign wi = stg[gi-1].wo;
      assign si = stg[gi-1].so;
    end

    assign t1 = si[7] + bsig1(si[4]) + ((si[4] & si[5]) ^ (~si[4] & si[6]))
              + K_ROM[cnt_q + 6'(gi)] + wi[0];
    assign t2 = bsig0(si[0]) + ((si[0] & si[1]) ^ (si[0] & si[2]) ^ (si[1] & si[2]));

    assign so[0] = t1 + t2;
    assign so[1] = si[0];
    assign so[2] = si[1];
    assign so[3] = si[2];
    assign so[4] = si[3] + t1;
    assign so[5] = si[4];
    assign so[6] = si[5];
    assign so[7] = si[6];

    // Word W[t+16] from the window where wi[k] = W[t+k].
    assign w_new = ssig1(wi[14]) + wi[9] + ssig0(wi[1]) + wi[0];

    for (genvar gk = 0; gk < 15; gk++) begin : g_shift
      assign wo[gk] = wi[gk+1];
    end
    assign wo[15] = w_new;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    w_d       = w_q;
    h_d       = h_q;
    digest_d  = digest_q;
    dv_d      = 1'b0;
    blk_ready = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          for (int i = 0; i < 8; i++) begin
            work_d[i] = blk_first ? IV[i] : h_q[i];
            // A new message restarts the chain so the update adds the IV.
            if (blk_first) h_d[i] = IV[i];
          end
          for (int i = 0; i < 16; i++) begin
            w_d[i] = blk_data[511 - 32*i -: 32];
          end
          cnt_d   = 6'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        busy   = 1'b1;
        work_d = stg[ROUNDS_PER_CYCLE-1].so;
        w_d    = stg[ROUNDS_PER_CYCLE-1].wo;
        cnt_d  = cnt_q + 6'(ROUNDS_PER_CYCLE);
        if (cnt_q == LAST_CNT) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + work_q[i];
          digest_d[255 - 32*i -: 32] = h_q[i] + work_q[i];
        end
        dv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      work_q   <= '{default: '0};
      w_q      <= '{default: '0};
      h_q      <= IV;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      w_q      <= w_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
    end
  end

  assign digest       = digest_q;
  assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// tb_sha256_block_engine
//   Drives three engines (1, 2 and 4 rounds per clock) from one stimulus
//   process; expected digests go into per-engine queues and a monitor per
//   engine pops and compares whenever digest_valid is seen.
module tb_sha256_block_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         blk_valid [3];
  logic         blk_ready [3];
  logic         busy      [3];
  logic         dv        [3];
  logic [255:0] dig       [3];
  logic [511:0] blk_data;
  logic         blk_first;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [255:0] exp_q [3][$];
  logic [255:0] mh [3];
  int           acc_edge [3];
  logic         b2b_seen [3];

  localparam int RC [3] = '{64, 32, 16};

  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- reference model: full-schedule compression ----------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- DUTs and monitors ----------------
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    logic [255:0] e_val;

    sha256_block_engine #(.ROUNDS_PER_CYCLE(1 << gi)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .blk_valid    (blk_valid[gi]),
      .blk_ready    (blk_ready[gi]),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .busy         (busy[gi]),
      .digest_valid (dv[gi]),
      .digest       (dig[gi])
    );

    always @(negedge clk) begin
      if (rst_n) begin
        if (dv[gi]) begin
          if (exp_q[gi].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_digest r%0d got=%h", 1 << gi, dig[gi]);
          end else begin
            e_val = exp_q[gi].pop_front();
            chk($sformatf("digest_r%0d", 1 << gi), dig[gi], e_val);
            chk($sformatf("latency_r%0d", 1 << gi), 256'(edge_cnt - acc_edge[gi]), 256'(RC[gi] + 1));
            $display("r%0d digest %h at edge %0d", 1 << gi, dig[gi], edge_cnt);
          end
          if (blk_valid[gi] && blk_ready[gi]) b2b_seen[gi] = 1'b1;
        end
        if (blk_valid[gi] && blk_ready[gi]) acc_edge[gi] = edge_cnt + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic send(input logic [2:0] mask, input logic [511:0] blk, input logic first,
                      input logic use_const, input logic [255:0] cval);
    int   waited;
    logic ok;
    logic [255:0] nv;
    waited = 0;
    forever begin
      ok = 1'b1;
      for (int k = 0; k < 3; k++) if (mask[k] && !blk_ready[k]) ok = 1'b0;
      if (ok) break;
      if (waited > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout mask=%b got=not_ready want=ready", mask);
        return;
      end
      @(posedge clk); #1;
      waited++;
    end
    blk_data  = blk;
    blk_first = first;
    for (int k = 0; k < 3; k++) begin
      blk_valid[k] = mask[k];
      if (mask[k]) begin
        nv = use_const ? cval : sha_compress(first ? IV256 : mh[k], blk);
        mh[k] = nv;
        exp_q[k].push_back(nv);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) blk_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0) begin
      if (waited > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout pending=%0d/%0d/%0d want=0",
                 exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        return;
      end
      @(posedge clk); #1;
      waited++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ready_r%0d", tag, 1 << k), 256'(blk_ready[k]), 256'(1));
      chk($sformatf("%s_busy_r%0d", tag, 1 << k), 256'(busy[k]), 256'(0));
      chk($sformatf("%s_dv_r%0d", tag, 1 << k), 256'(dv[k]), 256'(0));
      chk($sformatf("%s_digest_r%0d", tag, 1 << k), dig[k], 256'(0));
    end
  endtask

  initial begin
    logic [511:0] rb;
    int cnt;

    rst_n     = 1'b0;
    blk_data  = '0;
    blk_first = 1'b0;
    for (int k = 0; k < 3; k++) begin
      blk_valid[k] = 1'b0;
      mh[k]        = IV256;
      acc_edge[k]  = 0;
      b2b_seen[k]  = 1'b0;
    end
    #2;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer single blocks on all three fold factors.
    send(3'b111, B_ABC, 1'b1, 1'b1, D_ABC);
    drain();
    send(3'b111, B_EMPTY, 1'b1, 1'b1, D_EMPTY);
    drain();

    // Two-block message per engine; second block waits on ready and must be
    // taken in the digest_valid cycle of the first.
    for (int k = 0; k < 3; k++) begin
      b2b_seen[k] = 1'b0;
      send(3'(1 << k), B_TWO1, 1'b1, 1'b0, '0);
      send(3'(1 << k), B_TWO2, 1'b0, 1'b1, D_TWO);
      drain();
      chk($sformatf("b2b_accept_r%0d", 1 << k), 256'(b2b_seen[k]), 256'(1));
    end

    // Reset in the middle of a block: no digest may follow, and chaining
    // after reset starts from the IV.
    send(3'b111, B_ABC, 1'b1, 1'b1, D_ABC);
    repeat (29) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      mh[k] = IV256;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(3'b111, B_ABC, 1'b0, 1'b1, D_ABC);
    drain();

    // Hold blk_valid through ROUND with changing data on the 1-round engine.
    for (int i = 0; i < 16; i++) rb[511 - 32*i -: 32] = $urandom();
    send(3'b001, rb, 1'b1, 1'b0, '0);
    blk_valid[0] = 1'b1;
    cnt = 0;
    while (!blk_ready[0] && cnt < 100) begin
      for (int i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = $urandom();
      blk_first = 1'($urandom());
      @(posedge clk); #1;
      cnt++;
    end
    chk("hold_ready_low_cycles", 256'(cnt), 256'(RC[0] + 1));
    for (int i = 0; i < 16; i++) rb[511 - 32*i -: 32] = $urandom();
    send(3'b001, rb, 1'b0, 1'b0, '0);
    drain();

    // Randomised blocks, random chaining.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) rb[511 - 32*i -: 32] = $urandom();
      send(3'b111, rb, 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    drain();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
